// File: rtl/mac_seq_pkg.sv
// Shared types and fixed-point constants for the MAC sequencer and its requantizer.
// Q1.6 operands and Q.12 MAC results, both in sign-magnitude.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RELEASE,
    S_UPDATE,
    S_OUTPUT
  } state_t;

  localparam int FRAC_IN   = 6;
  localparam int FRAC_OUT  = 12;
  localparam int REQ_SHIFT = FRAC_OUT - FRAC_IN;

  // Largest magnitude a w-bit sign-magnitude word can carry.
  function automatic int sm_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Job, operand, MAC and result signals of the sequencer; master = sequencer side.
// ERR exists only when MACSEQ_TIMEOUT_EN is defined.
interface mac_sequencer_if #(
  parameter int D_W   = 8,
  parameter int M_W   = 16,
  parameter int LEN_W = 8
);
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic [D_W-1:0]   BIAS;
  logic             IN_VALID;
  logic             IN_READY;
  logic [D_W-1:0]   IN_A;
  logic [D_W-1:0]   IN_B;
  logic             MAC_EN;
  logic [D_W-1:0]   MAC_A;
  logic [D_W-1:0]   MAC_B;
  logic [D_W-1:0]   MAC_C;
  logic [M_W-1:0]   MAC_MOUT;
  logic             MAC_DONE;
  logic             RES_VALID;
  logic             RES_READY;
  logic [D_W-1:0]   RES_DATA;
  logic             RES_SAT;
  logic             BUSY;
`ifdef MACSEQ_TIMEOUT_EN
  logic             ERR;

  modport master (
    input  START, LEN, BIAS, IN_VALID, IN_A, IN_B, MAC_MOUT, MAC_DONE, RES_READY,
    output IN_READY, MAC_EN, MAC_A, MAC_B, MAC_C, RES_VALID, RES_DATA, RES_SAT, BUSY, ERR
  );
  modport slave (
    output START, LEN, BIAS, IN_VALID, IN_A, IN_B, MAC_MOUT, MAC_DONE, RES_READY,
    input  IN_READY, MAC_EN, MAC_A, MAC_B, MAC_C, RES_VALID, RES_DATA, RES_SAT, BUSY, ERR
  );
`else
  modport master (
    input  START, LEN, BIAS, IN_VALID, IN_A, IN_B, MAC_MOUT, MAC_DONE, RES_READY,
    output IN_READY, MAC_EN, MAC_A, MAC_B, MAC_C, RES_VALID, RES_DATA, RES_SAT, BUSY
  );
  modport slave (
    output START, LEN, BIAS, IN_VALID, IN_A, IN_B, MAC_MOUT, MAC_DONE, RES_READY,
    input  IN_READY, MAC_EN, MAC_A, MAC_B, MAC_C, RES_VALID, RES_DATA, RES_SAT, BUSY
  );
`endif
endinterface

// File: rtl/sm_requant.sv
// Combinational sign-magnitude requantizer: drops SHIFT fraction bits (toward zero),
// clamps the magnitude to the output range with a sat flag, and never emits negative zero.
module sm_requant
  import mac_seq_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = REQ_SHIFT
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);
  localparam logic [IN_W-2:0] MAX_MAG = (IN_W-1)'(sm_max(OUT_W));

  logic [IN_W-2:0]  mag_full;
  logic [OUT_W-2:0] mag;

  always_comb begin
    mag_full = din[IN_W-2:0] >> SHIFT;
    sat      = (mag_full > MAX_MAG);
    mag      = sat ? MAX_MAG[OUT_W-2:0] : mag_full[OUT_W-2:0];
    dout     = {din[IN_W-1] & (mag != '0), mag};
  end
endmodule

// File: rtl/mac_sequencer.sv
// Drives one MAC through an N-step dot product, feeding each requantized result back as C.
// Optional MAC watchdog with ERR output when MACSEQ_TIMEOUT_EN is defined.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int M_W   = 16,
  parameter int LEN_W = 8
`ifdef MACSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              CLK,
  input  logic              RSTn,
  mac_sequencer_if.master   bus
);
  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [D_W-1:0]   acc, a_q, b_q, rq_data;
  logic [M_W-1:0]   mout_q;
  logic             sat, rq_sat, timeout;

  sm_requant #(.IN_W(M_W), .OUT_W(D_W), .SHIFT(REQ_SHIFT)) u_requant (
    .din  (mout_q),
    .dout (rq_data),
    .sat  (rq_sat)
  );

`ifdef MACSEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;
  logic             err_q;

  assign timeout = ((state == S_ISSUE) || (state == S_RELEASE)) && (tmr == TMR_W'(TIMEOUT - 1));
  assign bus.ERR = err_q;

  // Counts cycles spent in the current state; every transition restarts it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_nxt != state)
        tmr <= '0;
      else if ((state == S_ISSUE) || (state == S_RELEASE))
        tmr <= tmr + 1'b1;
      if ((state == S_IDLE) && bus.START)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.IN_READY  = 1'b0;
    bus.MAC_EN    = 1'b0;
    bus.RES_VALID = 1'b0;
    bus.BUSY      = (state != S_IDLE);
    unique case (state)
      S_IDLE:    if (bus.START) state_nxt = (bus.LEN == '0) ? S_OUTPUT : S_FETCH;
      S_FETCH: begin
        bus.IN_READY = 1'b1;
        if (bus.IN_VALID) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.MAC_EN = !timeout;
        if (timeout)           state_nxt = S_OUTPUT;
        else if (bus.MAC_DONE) state_nxt = S_RELEASE;
      end
      // The MAC only rearms once DONE has fallen.
      S_RELEASE: begin
        if (timeout)            state_nxt = S_OUTPUT;
        else if (!bus.MAC_DONE) state_nxt = S_UPDATE;
      end
      S_UPDATE:  state_nxt = (cnt == LEN_W'(1)) ? S_OUTPUT : S_FETCH;
      S_OUTPUT: begin
        bus.RES_VALID = 1'b1;
        if (bus.RES_READY) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt    <= '0;
      acc    <= '0;
      sat    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      mout_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.START) begin
          cnt <= bus.LEN;
          acc <= bus.BIAS;
          sat <= 1'b0;
        end
        S_FETCH: if (bus.IN_VALID) begin
          a_q <= bus.IN_A;
          b_q <= bus.IN_B;
        end
        S_ISSUE: if (bus.MAC_DONE && !timeout) mout_q <= bus.MAC_MOUT;
        S_UPDATE: begin
          acc <= rq_data;
          sat <= sat | rq_sat;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.MAC_A    = a_q;
  assign bus.MAC_B    = b_q;
  assign bus.MAC_C    = acc;
  assign bus.RES_DATA = acc;
  assign bus.RES_SAT  = sat;
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC responder plus an arithmetic dot-product model.
// Covers the timeout path too when MACSEQ_TIMEOUT_EN is defined.
module tb_mac_sequencer;
  logic clk  = 1'b0;
  logic rstn = 1'b0;

  mac_sequencer_if bus ();
  mac_sequencer dut (.CLK(clk), .RSTn(rstn), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int mac_lat = 1, done_hold = 0;
  int en_count = 0, proto_err = 0;
  logic [23:0] seen_q[$];
  logic [7:0]  op_a[16], op_b[16];
  logic [7:0]  last_d;
  logic        last_s;
  int          last_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sm_val(input logic [7:0] v);
    int m;
    m = int'(v[6:0]);
    return v[7] ? -m : m;
  endfunction

  // Ideal MAC: A*B in Q.12 plus C promoted to Q.12, sign-magnitude out.
  function automatic logic [15:0] mac_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int p, m;
    p = sm_val(a) * sm_val(b) + sm_val(c) * 64;
    m = (p < 0) ? -p : p;
    if (m > 32767) m = 32767;
    return {(p < 0), m[14:0]};
  endfunction

  // Returns {sat, Q1.6 value} for a Q.12 MAC result.
  function automatic logic [8:0] rq_ref(input logic [15:0] mo);
    int q;
    logic s;
    q = int'(mo[14:0]) / 64;
    s = (q > 127);
    if (s) q = 127;
    return {s, (mo[15] && q != 0), q[6:0]};
  endfunction

  function automatic logic [36:0] outs();
    return {bus.IN_READY, bus.MAC_EN, bus.MAC_A, bus.MAC_B, bus.MAC_C,
            bus.RES_VALID, bus.RES_DATA, bus.RES_SAT, bus.BUSY};
  endfunction

  initial begin : mac_model
    int phase = 0, left = 0, hold = 0;
    logic [23:0] cap = '0;
    bus.MAC_DONE = 1'b0;
    bus.MAC_MOUT = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!rstn) begin
        bus.MAC_DONE = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (bus.MAC_EN) begin
            en_count++;
            cap = {bus.MAC_A, bus.MAC_B, bus.MAC_C};
            seen_q.push_back(cap);
            left  = mac_lat;
            phase = 1;
          end
          1: if (!bus.MAC_EN || ({bus.MAC_A, bus.MAC_B, bus.MAC_C} != cap)) proto_err++;
          2: begin
            if (bus.MAC_EN) proto_err++;
            else if (hold == 0) begin
              bus.MAC_DONE = 1'b0;
              phase = 0;
            end else hold--;
          end
          default: phase = 0;
        endcase
        if (phase == 1) begin
          left--;
          if (left <= 0) begin
            bus.MAC_MOUT = mac_fn(cap[23:16], cap[15:8], cap[7:0]);
            bus.MAC_DONE = 1'b1;
            hold  = done_hold;
            phase = 2;
          end
        end
      end
    end
  end

  task automatic run_job(input int len, input logic [7:0] bias, input int gap, input int stall, input string tag);
    logic [7:0]  exp_c[17];
    logic [8:0]  r;
    logic        exp_s;
    logic [23:0] got;
    int t0, w, en0, pe0, q0;
    exp_c[0] = bias;
    exp_s    = 1'b0;
    for (int i = 0; i < len; i++) begin
      r = rq_ref(mac_fn(op_a[i], op_b[i], exp_c[i]));
      exp_c[i+1] = r[7:0];
      exp_s |= r[8];
    end
    en0 = en_count; pe0 = proto_err; q0 = seen_q.size();
    bus.LEN = 8'(len); bus.BIAS = bias; bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    t0 = cyc;
    check({tag, "_busy"}, bus.BUSY, 1);
    for (int i = 0; i < len; i++) begin
      w = 0;
      while (!bus.IN_READY && w < 300) begin @(posedge clk); #1; w++; end
      check({tag, "_fetch_wait"}, bus.IN_READY, 1);
      for (int g = 0; g < gap; g++) begin
        check({tag, "_starve"}, {bus.MAC_EN, bus.IN_READY}, 2'b01);
        @(posedge clk); #1;
      end
      bus.IN_VALID = 1'b1; bus.IN_A = op_a[i]; bus.IN_B = op_b[i];
      @(posedge clk); #1;
      bus.IN_VALID = 1'b0;
    end
    w = 0;
    while (!bus.RES_VALID && w < 500) begin @(posedge clk); #1; w++; end
    last_lat = cyc - t0;
    check({tag, "_res_valid"}, bus.RES_VALID, 1);
    check({tag, "_res_data"}, bus.RES_DATA, exp_c[len]);
    check({tag, "_res_sat"}, bus.RES_SAT, exp_s);
    last_d = bus.RES_DATA;
    last_s = bus.RES_SAT;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {bus.RES_VALID, bus.RES_DATA, bus.RES_SAT}, {1'b1, exp_c[len], exp_s});
    end
    bus.RES_READY = 1'b1;
    @(posedge clk); #1;
    bus.RES_READY = 1'b0;
    check({tag, "_drained"}, {bus.RES_VALID, bus.BUSY}, 2'b00);
    check({tag, "_en_count"}, en_count - en0, len);
    check({tag, "_mac_proto"}, proto_err - pe0, 0);
    check({tag, "_mac_reqs"}, seen_q.size() - q0, len);
    for (int i = 0; i < len && (q0 + i) < seen_q.size(); i++) begin
      got = seen_q[q0+i];
      check({tag, "_mac_abc"}, got, {op_a[i], op_b[i], exp_c[i]});
    end
  endtask

  initial begin : stim
    int base, w;
    logic [23:0] got;
    bus.START = 0; bus.LEN = 0; bus.BIAS = 0; bus.IN_VALID = 0;
    bus.IN_A = 0; bus.IN_B = 0; bus.RES_READY = 0;
    #2;
    check("reset_outs", outs(), 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("idle_outs", outs(), 0);

    op_a[0] = 8'h20; op_b[0] = 8'h20;
    run_job(1, 8'h00, 0, 0, "pos");
    check("pos_data", last_d, 8'h10);
    check("pos_sat", last_s, 1'b0);
    check("pos_latency", last_lat, 4);

    op_a[0] = 8'hA0; op_b[0] = 8'h20;
    run_job(1, 8'h00, 0, 0, "neg");
    check("neg_data", last_d, 8'h90);

    op_a[0] = 8'h7F; op_b[0] = 8'h7F;
    run_job(1, 8'h00, 0, 0, "clamp");
    check("clamp_data", {last_s, last_d}, {1'b1, 8'h7F});

    for (int i = 0; i < 3; i++) begin op_a[i] = 8'h40; op_b[i] = 8'h40; end
    base = seen_q.size();
    run_job(3, 8'h40, 0, 0, "sticky");
    for (int i = 0; i < 3 && (base + i) < seen_q.size(); i++) begin
      got = seen_q[base+i];
      check("sticky_mac_c", got[7:0], (i == 0) ? 8'h40 : 8'h7F);
    end
    check("sticky_res", {last_s, last_d}, {1'b1, 8'h7F});

    op_a[0] = 8'h30; op_b[0] = 8'hC8; op_a[1] = 8'h11; op_b[1] = 8'h22;
    mac_lat = 2; done_hold = 3;
    run_job(2, 8'h05, 5, 4, "bp");
    mac_lat = 1; done_hold = 0;

    run_job(0, 8'h85, 0, 0, "len0");
    check("len0_latency", last_lat, 0);
    check("len0_data", last_d, 8'h85);

    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        op_a[i] = 8'($urandom_range(0, 255));
        op_b[i] = 8'($urandom_range(0, 255));
      end
      mac_lat   = $urandom_range(1, 4);
      done_hold = $urandom_range(0, 3);
      run_job(n, 8'($urandom_range(0, 255)), $urandom_range(0, 2), $urandom_range(0, 2), "rnd");
    end
    mac_lat = 20; done_hold = 0;

    bus.LEN = 8'd2; bus.BIAS = 8'h11; bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.IN_VALID = 1'b1; bus.IN_A = 8'h33; bus.IN_B = 8'h44;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    w = 0;
    while (!bus.MAC_EN && w < 50) begin @(posedge clk); #1; w++; end
    check("rst_in_issue", bus.MAC_EN, 1);
    rstn = 1'b0;
    #1;
    check("rst_async_outs", outs(), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_idle_outs", outs(), 0);

`ifdef MACSEQ_TIMEOUT_EN
    mac_lat = 100000;
    op_a[0] = 8'h01; op_b[0] = 8'h01;
    bus.LEN = 8'd1; bus.BIAS = 8'h23; bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0; base = cyc;
    bus.IN_VALID = 1'b1; bus.IN_A = op_a[0]; bus.IN_B = op_b[0];
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    w = 0;
    while (!bus.RES_VALID && w < 200) begin @(posedge clk); #1; w++; end
    check("to_valid", bus.RES_VALID, 1);
    check("to_latency", cyc - base, 65);
    check("to_err_data", {bus.ERR, bus.MAC_EN, bus.RES_DATA}, {2'b10, 8'h23});
    bus.RES_READY = 1'b1;
    @(posedge clk); #1;
    bus.RES_READY = 1'b0;
    check("to_err_held", {bus.ERR, bus.BUSY}, 2'b10);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    mac_lat = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Initiator for the MAC EN/DONE handshake. Computes an N-element dot product by streaming operand pairs into the MAC.
- After each MAC result, requantizes MOUT (Q.12) to the 8-bit Q1.6 sign-magnitude C format and feeds it back as the next accumulator. Each step is result = A*B + C_prev.
- Sits between the operand buffer stream (valid/ready) and one MAC instance; emits one 8-bit result per job on a valid/ready output.

Parameters:
- D_W, 8, operand/accumulator width; sign-magnitude, bit D_W-1 = sign, 6 fraction bits
- M_W, 16, MAC MOUT width; bit M_W-1 = sign, 12 fraction bits
- LEN_W, 8, width of job length field (max N = 2^LEN_W-1)
- TIMEOUT, 64, watchdog limit in cycles (used only with MACSEQ_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RSTn  in  1  async active-low reset
- START  in  1  job start pulse; sampled only in IDLE
- LEN  in  LEN_W  number of operand pairs; latched on START
- BIAS  in  D_W  initial C value; latched on START
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  sequencer accepts pair
- IN_A  in  D_W  operand A
- IN_B  in  D_W  operand B
- MAC_EN  out  1  request to MAC
- MAC_A  out  D_W  A to MAC
- MAC_B  out  D_W  B to MAC
- MAC_C  out  D_W  C to MAC (running accumulator)
- MAC_MOUT  in  M_W  MAC result
- MAC_DONE  in  1  MAC completion flag
- RES_VALID  out  1  result valid
- RES_READY  in  1  consumer ready
- RES_DATA  out  D_W  final accumulator, Q1.6 sign-magnitude
- RES_SAT  out  1  any step saturated during the job
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: RSTn is an asynchronous, active-low reset; the clock is CLK. While reset is asserted, every output is 0 and the state is IDLE. Asserting reset mid-job aborts the job; no result is emitted.
- States: IDLE, FETCH, ISSUE, RELEASE, UPDATE, OUTPUT.
- IDLE:
  - On START=1: latch LEN into cnt, BIAS into acc, clear sat.
  - If LEN=0, go to OUTPUT with RES_DATA=BIAS. Otherwise go to FETCH.
  - START outside IDLE is ignored.
- FETCH:
  - IN_READY=1 only in this state.
  - On IN_VALID&IN_READY: register A/B onto MAC_A/MAC_B, then go to ISSUE.
- ISSUE:
  - MAC_EN=1.
  - MAC_A, MAC_B and MAC_C=acc are held stable until MAC_DONE=1 is sampled.
  - On MAC_DONE=1: capture MAC_MOUT, go to RELEASE.
- RELEASE:
  - MAC_EN=0.
  - Wait for MAC_DONE=0; the MAC does not restart while DONE is high.
  - Then go to UPDATE.
  - If MAC_DONE is already low on entry, exit after 1 cycle.
- UPDATE (1 cycle):
  - mag = captured[M_W-2:0] >> 6, truncated toward zero.
  - If mag > 2^(D_W-1)-1: clamp to 127 and set sat.
  - acc = {sign, mag}. A zero magnitude forces sign=0 (no negative zero).
  - cnt decrements. If cnt reaches 0, go to OUTPUT; else go to FETCH.
- OUTPUT:
  - RES_VALID=1, with RES_DATA=acc and RES_SAT=sat.
  - Hold until RES_READY, then go to IDLE.
  - When RES_VALID and RES_READY are both high in the same cycle, the transfer completes that cycle.
- Minimum per-element latency: 1 (FETCH) + MAC latency + 1 (RELEASE) + 1 (UPDATE) cycles.
- MAC_A/B/C are registered outputs; no combinational path from IN_* to MAC_*.

Optional Feature:
- Macro: MACSEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE and RELEASE and resets on every state entry.
  - Reaching TIMEOUT drops MAC_EN and goes to OUTPUT with RES_DATA=acc at the moment of the timeout.
  - An extra output port ERR out 1 is set and held until the next START.
- Undefined: no counter, no ERR port; the sequencer waits indefinitely.

Decomposition:
- Package mac_seq_pkg:
  - state enum
  - FRAC_IN=6, FRAC_OUT=12, REQ_SHIFT=FRAC_OUT-FRAC_IN
  - sign-magnitude max constant
- Sub-module sm_requant: combinational M_W→D_W sign-magnitude shift, saturation and negative-zero normalization, with a sat output. It is reused by later accumulator blocks.

Test Plan:
- LEN=1, BIAS=0x00, A=0x20, B=0x20; MAC model returns 0x0400 → RES_DATA=0x10, RES_SAT=0, exactly one EN assertion.
- LEN=1, A=0xA0, B=0x20; model returns 0x8400 → RES_DATA=0x90 (−0.25).
- LEN=1, A=0x7F, B=0x7F; model returns 0x3F01 → mag 252 clamps → RES_DATA=0x7F, RES_SAT=1.
- LEN=3, BIAS=0x40, pairs (0x40,0x40)×3 with MAC_C checked each step (0x40, 0x7F, 0x7F) → saturation is sticky, final RES_DATA=0x7F, RES_SAT=1.
- Back-pressure: IN_VALID low for 5 cycles, RES_READY low for 4 cycles → MAC_EN stays 0 while starved, RES_VALID and RES_DATA stable until the handshake. MAC_DONE held high 3 cycles past capture → no new EN until it drops.
- LEN=0, BIAS=0x85 → RES_VALID the cycle after START with 0x85, MAC_EN never asserted. Also: RSTn low during ISSUE → all outputs 0 immediately, then IDLE. With MACSEQ_TIMEOUT_EN and MAC_DONE never asserted → ERR=1 after 64 cycles.
